// File: rtl/execute_pkg.sv
// Shared MIPS pipeline definitions: control-bus bit positions, ALUOp codes,
// R-type funct codes, forward-select codes and internal ALU operations.
package mips_defs;

    // in_execute_bus = {RegDst, ALUSrc, ALUOp[1:0]}
    localparam int unsigned EX_REG_DST   = 3;
    localparam int unsigned EX_ALU_SRC   = 2;
    localparam int unsigned EX_ALU_OP_HI = 1;
    localparam int unsigned EX_ALU_OP_LO = 0;

    // in_memory_bus = {MemRead, MemWrite, Branch}
    localparam int unsigned MEM_READ   = 2;
    localparam int unsigned MEM_WRITE  = 1;
    localparam int unsigned MEM_BRANCH = 0;

    // in_writeBack_bus = {RegWrite, MemtoReg}
    localparam int unsigned WB_REG_WRITE  = 1;
    localparam int unsigned WB_MEM_TO_REG = 0;

    // ALUOp field driven by the main decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_LUI   = 2'b11
    } alu_op_e;

    // R-type funct field
    typedef enum logic [5:0] {
        FN_SLL  = 6'b000000,
        FN_SRL  = 6'b000010,
        FN_SRA  = 6'b000011,
        FN_ADD  = 6'b100000,
        FN_SUB  = 6'b100010,
        FN_AND  = 6'b100100,
        FN_OR   = 6'b100101,
        FN_XOR  = 6'b100110,
        FN_NOR  = 6'b100111,
        FN_SLT  = 6'b101010,
        FN_SLTU = 6'b101011
    } funct_e;

    // Operand source select from the forwarding unit; 11 behaves like 00
    typedef enum logic [1:0] {
        FWD_DECODE = 2'b00,
        FWD_MEM    = 2'b01,
        FWD_WB     = 2'b10,
        FWD_ALIAS  = 2'b11
    } fwd_sel_e;

    // Operation actually performed by the ALU
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11,
        ALU_NONE = 4'd12
    } alu_ctl_e;

endpackage

// File: rtl/execute_alu.sv
// Combinational ALU for the EX stage. Shifts use shamt on operand b.
module alu
    import mips_defs::*;
#(
    parameter int unsigned len = 32
) (
    input  logic [len-1:0] a,
    input  logic [len-1:0] b,
    input  logic [4:0]     shamt,
    input  logic [3:0]     op,
    output logic [len-1:0] result,
    output logic           zero
);

    // Select the operation result; unknown ops produce 0
    always_comb begin
        result = '0;
        case (alu_ctl_e'(op))
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLT:  result = {{(len-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(len-1){1'b0}}, (a < b)};
            ALU_SLL:  result = b << shamt;
            ALU_SRL:  result = b >> shamt;
            ALU_SRA:  result = $unsigned($signed(b) >>> shamt);
            ALU_LUI:  result = b << 16;
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/execute.sv
// EX stage: operand forwarding, ALU control decode, ALU, branch target and
// the EX/MEM pipeline register (flush beats stall).
module execute
    import mips_defs::*;
#(
    parameter int unsigned len    = 32,
    parameter int unsigned NB_REG = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [len-1:0]    in_pc_jump,
    input  logic [len-1:0]    in_reg1,
    input  logic [len-1:0]    in_reg2,
    input  logic [len-1:0]    in_sign_extend,
    input  logic [NB_REG-1:0] in_rt,
    input  logic [NB_REG-1:0] in_rd,
    input  logic [3:0]        in_execute_bus,
    input  logic [2:0]        in_memory_bus,
    input  logic [1:0]        in_writeBack_bus,
    input  logic [1:0]        in_forward_a,
    input  logic [1:0]        in_forward_b,
    input  logic [len-1:0]    in_fwd_mem,
    input  logic [len-1:0]    in_fwd_wb,
    input  logic              in_stall,
    input  logic              in_flush,
    output logic [len-1:0]    out_pc_branch,
    output logic              out_zero,
    output logic [len-1:0]    out_alu_result,
    output logic [len-1:0]    out_store_data,
    output logic [NB_REG-1:0] out_write_reg,
    output logic [2:0]        out_memory_bus,
    output logic [1:0]        out_writeBack_bus
);

    logic [len-1:0]    opnd_a;
    logic [len-1:0]    fwd_rt;
    logic [len-1:0]    opnd_b;
    logic [3:0]        alu_ctl;
    logic [len-1:0]    alu_result;
    logic              alu_zero;
    logic [len-1:0]    pc_branch;
    logic [NB_REG-1:0] write_reg;
    logic [1:0]        alu_op;
    logic [5:0]        funct;

    assign alu_op = in_execute_bus[EX_ALU_OP_HI:EX_ALU_OP_LO];
    assign funct  = in_sign_extend[5:0];

    // Forwarding muxes for rs and rt
    always_comb begin
        opnd_a = in_reg1;
        fwd_rt = in_reg2;
        case (fwd_sel_e'(in_forward_a))
            FWD_MEM: opnd_a = in_fwd_mem;
            FWD_WB:  opnd_a = in_fwd_wb;
            default: opnd_a = in_reg1;
        endcase
        case (fwd_sel_e'(in_forward_b))
            FWD_MEM: fwd_rt = in_fwd_mem;
            FWD_WB:  fwd_rt = in_fwd_wb;
            default: fwd_rt = in_reg2;
        endcase
    end

    assign opnd_b    = in_execute_bus[EX_ALU_SRC] ? in_sign_extend : fwd_rt;
    assign pc_branch = in_pc_jump + (in_sign_extend << 2);
    assign write_reg = in_execute_bus[EX_REG_DST] ? in_rd : in_rt;

    // ALU control: ALUOp first, funct decode only for R-type
    always_comb begin
        alu_ctl = ALU_NONE;
        case (alu_op_e'(alu_op))
            ALUOP_ADD: alu_ctl = ALU_ADD;
            ALUOP_SUB: alu_ctl = ALU_SUB;
            ALUOP_LUI: alu_ctl = ALU_LUI;
            default: begin
                case (funct_e'(funct))
                    FN_ADD:  alu_ctl = ALU_ADD;
                    FN_SUB:  alu_ctl = ALU_SUB;
                    FN_AND:  alu_ctl = ALU_AND;
                    FN_OR:   alu_ctl = ALU_OR;
                    FN_XOR:  alu_ctl = ALU_XOR;
                    FN_NOR:  alu_ctl = ALU_NOR;
                    FN_SLT:  alu_ctl = ALU_SLT;
                    FN_SLTU: alu_ctl = ALU_SLTU;
                    FN_SLL:  alu_ctl = ALU_SLL;
                    FN_SRL:  alu_ctl = ALU_SRL;
                    FN_SRA:  alu_ctl = ALU_SRA;
                    default: alu_ctl = ALU_NONE;
                endcase
            end
        endcase
    end

    alu #(
        .len (len)
    ) u_alu (
        .a      (opnd_a),
        .b      (opnd_b),
        .shamt  (in_sign_extend[10:6]),
        .op     (alu_ctl),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // EX/MEM register: reset, then flush, then stall, then load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_pc_branch     <= '0;
            out_zero          <= 1'b0;
            out_alu_result    <= '0;
            out_store_data    <= '0;
            out_write_reg     <= '0;
            out_memory_bus    <= '0;
            out_writeBack_bus <= '0;
        end else if (in_flush) begin
            out_pc_branch     <= '0;
            out_zero          <= 1'b0;
            out_alu_result    <= '0;
            out_store_data    <= '0;
            out_write_reg     <= '0;
            out_memory_bus    <= '0;
            out_writeBack_bus <= '0;
        end else if (!in_stall) begin
            out_pc_branch     <= pc_branch;
            out_zero          <= alu_zero;
            out_alu_result    <= alu_result;
            out_store_data    <= fwd_rt;
            out_write_reg     <= write_reg;
            out_memory_bus    <= in_memory_bus;
            out_writeBack_bus <= in_writeBack_bus;
        end
    end

endmodule

// File: tb/tb_execute.sv
// Directed self-checking bench for the EX stage.
module tb_execute;

    logic        clk;
    logic        reset;
    logic [31:0] in_pc_jump;
    logic [31:0] in_reg1;
    logic [31:0] in_reg2;
    logic [31:0] in_sign_extend;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [3:0]  in_execute_bus;
    logic [2:0]  in_memory_bus;
    logic [1:0]  in_writeBack_bus;
    logic [1:0]  in_forward_a;
    logic [1:0]  in_forward_b;
    logic [31:0] in_fwd_mem;
    logic [31:0] in_fwd_wb;
    logic        in_stall;
    logic        in_flush;
    logic [31:0] out_pc_branch;
    logic        out_zero;
    logic [31:0] out_alu_result;
    logic [31:0] out_store_data;
    logic [4:0]  out_write_reg;
    logic [2:0]  out_memory_bus;
    logic [1:0]  out_writeBack_bus;

    int unsigned n_checks;
    int unsigned n_pass;

    execute #(
        .len    (32),
        .NB_REG (5)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .in_pc_jump        (in_pc_jump),
        .in_reg1           (in_reg1),
        .in_reg2           (in_reg2),
        .in_sign_extend    (in_sign_extend),
        .in_rt             (in_rt),
        .in_rd             (in_rd),
        .in_execute_bus    (in_execute_bus),
        .in_memory_bus     (in_memory_bus),
        .in_writeBack_bus  (in_writeBack_bus),
        .in_forward_a      (in_forward_a),
        .in_forward_b      (in_forward_b),
        .in_fwd_mem        (in_fwd_mem),
        .in_fwd_wb         (in_fwd_wb),
        .in_stall          (in_stall),
        .in_flush          (in_flush),
        .out_pc_branch     (out_pc_branch),
        .out_zero          (out_zero),
        .out_alu_result    (out_alu_result),
        .out_store_data    (out_store_data),
        .out_write_reg     (out_write_reg),
        .out_memory_bus    (out_memory_bus),
        .out_writeBack_bus (out_writeBack_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Advance one edge and sample 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_defaults();
        in_pc_jump       = '0;
        in_reg1          = '0;
        in_reg2          = '0;
        in_sign_extend   = '0;
        in_rt            = '0;
        in_rd            = '0;
        in_execute_bus   = '0;
        in_memory_bus    = '0;
        in_writeBack_bus = '0;
        in_forward_a     = '0;
        in_forward_b     = '0;
        in_fwd_mem       = '0;
        in_fwd_wb        = '0;
        in_stall         = 1'b0;
        in_flush         = 1'b0;
    endtask

    // R-type with forwarding off: funct/shamt in sign_extend, RegDst=1
    task automatic rtype(input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] fn, input logic [4:0] sh);
        set_defaults();
        in_reg1        = a;
        in_reg2        = b;
        in_execute_bus = 4'b1010;
        in_sign_extend = {21'd0, sh, fn};
        in_rd          = 5'd4;
        in_rt          = 5'd9;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        set_defaults();
        reset = 1'b0;
        in_reg1 = 32'h55;
        in_execute_bus = 4'b1010;
        in_sign_extend = 32'h20;
        in_memory_bus = 3'b111;
        in_writeBack_bus = 2'b11;
        step();
        step();
        check("rst_alu",  out_alu_result, 32'h0);
        check("rst_zero", {31'd0, out_zero}, 32'h0);
        check("rst_pcb",  out_pc_branch, 32'h0);
        check("rst_mem",  {29'd0, out_memory_bus}, 32'h0);
        check("rst_wb",   {30'd0, out_writeBack_bus}, 32'h0);
        check("rst_wreg", {27'd0, out_write_reg}, 32'h0);
        #2 reset = 1'b1;

        // R-type ADD 5+7
        set_defaults();
        in_reg1 = 32'd5; in_reg2 = 32'd7;
        in_execute_bus = 4'b1010; in_sign_extend = 32'h20;
        in_rd = 5'd3; in_rt = 5'd9; in_writeBack_bus = 2'b10;
        step();
        check("add_res",  out_alu_result, 32'd12);
        check("add_wreg", {27'd0, out_write_reg}, 32'd3);
        check("add_zero", {31'd0, out_zero}, 32'd0);
        check("add_wb",   {30'd0, out_writeBack_bus}, 32'h2);

        // SUB to zero with branch target
        set_defaults();
        in_reg1 = 32'h1234; in_reg2 = 32'h1234;
        in_execute_bus = 4'b0001; in_pc_jump = 32'h100; in_sign_extend = 32'd4;
        in_rt = 5'd7; in_rd = 5'd2; in_memory_bus = 3'b001;
        step();
        check("sub_res",  out_alu_result, 32'h0);
        check("sub_zero", {31'd0, out_zero}, 32'd1);
        check("sub_pcb",  out_pc_branch, 32'h110);
        check("sub_wreg", {27'd0, out_write_reg}, 32'd7);
        check("sub_mem",  {29'd0, out_memory_bus}, 32'h1);

        // Negative offset branch target wraps
        set_defaults();
        in_pc_jump = 32'h100; in_sign_extend = 32'hFFFF_FFFE;
        step();
        check("pcb_neg", out_pc_branch, 32'h0F8);

        // Forwarding: A from MEM, B from WB, SUB
        set_defaults();
        in_reg1 = 32'h111; in_reg2 = 32'h222;
        in_forward_a = 2'b01; in_fwd_mem = 32'hA;
        in_forward_b = 2'b10; in_fwd_wb = 32'h3;
        in_execute_bus = 4'b1010; in_sign_extend = 32'h22;
        step();
        check("fwd_sub",   out_alu_result, 32'd7);
        check("fwd_store", out_store_data, 32'd3);

        // ALUSrc immediate; store data still the forwarded rt
        in_execute_bus = 4'b0100; in_sign_extend = 32'd8;
        in_rt = 5'd6; in_rd = 5'd1; in_memory_bus = 3'b010;
        step();
        check("imm_res",   out_alu_result, 32'h12);
        check("imm_store", out_store_data, 32'd3);
        check("imm_wreg",  {27'd0, out_write_reg}, 32'd6);

        // Forward select 11 behaves like 00
        set_defaults();
        in_reg1 = 32'd20; in_reg2 = 32'd5;
        in_forward_a = 2'b11; in_forward_b = 2'b11;
        in_fwd_mem = 32'd1000; in_fwd_wb = 32'd2000;
        in_execute_bus = 4'b1010; in_sign_extend = 32'h20;
        step();
        check("fwd11_res",   out_alu_result, 32'd25);
        check("fwd11_store", out_store_data, 32'd5);

        // Shifts, logic, compares
        rtype(32'h0, 32'hF000_0000, 6'b000011, 5'd4); step();
        check("sra",  out_alu_result, 32'hFF00_0000);
        rtype(32'h0, 32'hF000_0000, 6'b000010, 5'd4); step();
        check("srl",  out_alu_result, 32'h0F00_0000);
        rtype(32'h0, 32'h0000_0081, 6'b000000, 5'd31); step();
        check("sll",  out_alu_result, 32'h8000_0000);
        rtype(32'hFFFF_FFFF, 32'h1, 6'b101010, 5'd0); step();
        check("slt",  out_alu_result, 32'd1);
        rtype(32'hFFFF_FFFF, 32'h1, 6'b101011, 5'd0); step();
        check("sltu", out_alu_result, 32'd0);
        check("sltu_zero", {31'd0, out_zero}, 32'd1);
        rtype(32'hF0F0_1234, 32'h0FF0_00FF, 6'b100100, 5'd0); step();
        check("and",  out_alu_result, 32'h00F0_0034);
        rtype(32'hF0F0_1234, 32'h0FF0_00FF, 6'b100101, 5'd0); step();
        check("or",   out_alu_result, 32'hFFF0_12FF);
        rtype(32'hF0F0_1234, 32'h0FF0_00FF, 6'b100110, 5'd0); step();
        check("xor",  out_alu_result, 32'hFF00_12CB);
        rtype(32'hF0F0_1234, 32'h0FF0_00FF, 6'b100111, 5'd0); step();
        check("nor",  out_alu_result, 32'h000F_ED00);
        rtype(32'hFFFF_FFFF, 32'h2, 6'b100000, 5'd0); step();
        check("add_wrap", out_alu_result, 32'h1);
        rtype(32'h5, 32'h7, 6'b111111, 5'd0); step();
        check("bad_funct", out_alu_result, 32'h0);
        check("bad_zero",  {31'd0, out_zero}, 32'd1);

        // LUI
        set_defaults();
        in_execute_bus = 4'b0111; in_sign_extend = 32'h1234;
        step();
        check("lui", out_alu_result, 32'h1234_0000);

        // Load a known value, then stall three edges with changing inputs
        set_defaults();
        in_reg1 = 32'd5; in_reg2 = 32'd7;
        in_execute_bus = 4'b1010; in_sign_extend = 32'h20; in_rd = 5'd3;
        in_memory_bus = 3'b010; in_writeBack_bus = 2'b10;
        step();
        check("pre_stall", out_alu_result, 32'd12);
        in_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_reg1 = 32'd100 + 32'(i);
            in_rd = 5'd20 + 5'(i);
            in_memory_bus = 3'b100;
            in_writeBack_bus = 2'b01;
            step();
            check("stall_res",  out_alu_result, 32'd12);
            check("stall_wreg", {27'd0, out_write_reg}, 32'd3);
            check("stall_mem",  {29'd0, out_memory_bus}, 32'h2);
        end

        // Flush overrides stall
        in_flush = 1'b1;
        step();
        check("flush_mem", {29'd0, out_memory_bus}, 32'h0);
        check("flush_wb",  {30'd0, out_writeBack_bus}, 32'h0);
        check("flush_res", out_alu_result, 32'h0);
        in_flush = 1'b0;
        in_stall = 1'b0;

        // Async reset between edges
        set_defaults();
        in_reg1 = 32'd1; in_reg2 = 32'd2;
        in_execute_bus = 4'b1010; in_sign_extend = 32'h20;
        in_writeBack_bus = 2'b11; in_memory_bus = 3'b101;
        step();
        check("pre_rst", out_alu_result, 32'd3);
        #2 reset = 1'b0;
        #1;
        check("arst_res", out_alu_result, 32'h0);
        check("arst_wb",  {30'd0, out_writeBack_bus}, 32'h0);
        check("arst_mem", {29'd0, out_memory_bus}, 32'h0);
        check("arst_pcb", out_pc_branch, 32'h0);
        #1 reset = 1'b1;
        in_reg1 = 32'd40; in_reg2 = 32'd2;
        step();
        check("post_rst",    out_alu_result, 32'd42);
        check("post_rst_wb", {30'd0, out_writeBack_bus}, 32'h3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/execute.md
Name: execute

Overview:
- EX stage of the 5-stage MIPS pipeline. Sits directly downstream of `decode` and consumes its register operands, sign-extended immediate, rt/rd fields and control buses.
- Performs operand forwarding muxing, the ALU operation and branch-target computation.
- Registers all results into the EX/MEM pipeline register that feeds the memory stage.

Parameters:
- len, 32, datapath width (PC, operands, results)
- NB_REG, 5, register-address width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- in_pc_jump  in  len  PC+4 from decode
- in_reg1  in  len  rs operand
- in_reg2  in  len  rt operand
- in_sign_extend  in  len  sign-extended immediate; [5:0]=funct, [10:6]=shamt
- in_rt  in  NB_REG  rt field
- in_rd  in  NB_REG  rd field
- in_execute_bus  in  4  {RegDst, ALUSrc, ALUOp[1:0]}
- in_memory_bus  in  3  {MemRead, MemWrite, Branch}
- in_writeBack_bus  in  2  {RegWrite, MemtoReg}
- in_forward_a  in  2  rs source select
- in_forward_b  in  2  rt source select
- in_fwd_mem  in  len  ALU result currently in EX/MEM
- in_fwd_wb  in  len  write-back data from the WB stage
- in_stall  in  1  hold EX/MEM register
- in_flush  in  1  insert bubble
- out_pc_branch  out  len  branch target
- out_zero  out  1  ALU result equals zero
- out_alu_result  out  len  ALU result
- out_store_data  out  len  forwarded rt value, used for SW
- out_write_reg  out  NB_REG  destination register
- out_memory_bus  out  3  registered memory control
- out_writeBack_bus  out  2  registered write-back control

Behaviour:
- Reset (reset==0, async): every output clears to 0.
- Forward select (applies to both operands):
  - 00 selects the decode operand.
  - 01 selects in_fwd_mem.
  - 10 selects in_fwd_wb.
  - 11 is treated as 00.
- ALU operand A = forwarded rs.
- ALU operand B = ALUSrc ? in_sign_extend : forwarded rt.
- out_store_data = forwarded rt, regardless of ALUSrc.
- ALU control:
  - ALUOp 00 → ADD.
  - ALUOp 01 → SUB.
  - ALUOp 11 → LUI, result = B<<16.
  - ALUOp 10 → decode by funct:
    - 100000 ADD, 100010 SUB.
    - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR.
    - 101010 SLT (signed), 101011 SLTU.
    - 000000 SLL, 000010 SRL, 000011 SRA; shift amount = shamt, shifted operand = B.
    - Any other funct → result 0.
- Arithmetic is modulo 2^len; no overflow trap.
- SLT/SLTU return 1 or 0, zero-extended.
- Branch target: in_pc_jump + (in_sign_extend<<2), truncated to len bits.
- Destination register: out_write_reg = RegDst ? in_rd : in_rt.
- Latency: 1 cycle. Inputs sampled on posedge clk; results visible after that edge.
- Per-edge priority (highest first):
  - reset low → all outputs 0.
  - in_flush → out_memory_bus and out_writeBack_bus load 0, all data outputs load 0.
  - in_stall → every output holds its value.
  - otherwise → load the newly computed values.
- Flush overrides stall when both are asserted on the same edge.
- Reset deasserted mid-stream: the first edge after release loads normally; no residual state.

Decomposition:
- Shared package `mips_defs`:
  - bus bit-position constants (RegDst=3, ALUSrc=2, ALUOp=1:0, MemRead=2, MemWrite=1, Branch=0, RegWrite=1, MemtoReg=0).
  - ALUOp codes.
  - funct codes.
  - forward-select codes.
- One combinational sub-module `alu`:
  - inputs a, b, shamt, 4-bit op.
  - outputs result, zero.
- ALU-control decode and the EX/MEM register stay in `execute`.

Test Plan:
- R-type ADD: reg1=5, reg2=7, execute_bus=1_0_10, funct=100000, rd=3 → next edge alu_result=12, write_reg=3, zero=0.
- SUB with zero plus branch: reg1=reg2=0x1234, ALUOp=01, pc_jump=0x100, imm=4 → alu_result=0, zero=1, pc_branch=0x110.
- Forwarding and SW store data:
  - forward_a=01 (fwd_mem=0xA), forward_b=10 (fwd_wb=0x3), funct SUB → result=7.
  - ALUSrc=1, imm=8 → result=0x12, store_data=3.
- Shifts and SLT:
  - SRA, shamt=4, B=0xF0000000 → 0xFF000000.
  - SLT, A=-1, B=1 → 1.
  - SLTU, A=0xFFFFFFFF, B=1 → 0.
- Stall and flush:
  - stall=1 for 3 edges while inputs change → outputs constant.
  - stall=1 with flush=1 → memory/writeBack buses become 0.
- Async reset mid-run: drop reset between edges → all outputs 0 immediately. Release reset → the next edge loads normally.
